threshold_stream_filter: RTL and testbench

- Streaming, parametrised successor of the row-based binary threshold filter. Accepts LANES RGB pixels per beat over a valid/ready handshake and tracks frame position internally. Converts each pixel to grayscale with a selectable method and applies one of four threshold modes, with thresholds latched per frame.
- Sits between the pixel source and the frame writer in the image-processing chain. Also reports a per-frame count of white (passing) pixels.

---
 rtl/threshold_stream_filter.sv | 230 +++++++++++++++++++++++
 tb/tb_threshold_stream_filter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_stream_filter.sv
// Streaming binary threshold filter: LANES RGB pixels per beat in, thresholded
// pixels out two cycles later, plus a per-frame count of passing pixels.
// Handshake: a beat moves on a side when valid & ready are both high at the
// rising clock edge; valid never waits for ready, and a held beat keeps its
// data stable until taken. Both pipeline stages advance together on
// adv = !s2_valid | out_ready, so in_ready is exactly adv.
module threshold_stream_filter #(
  parameter int PW        = 8,
  parameter int LANES     = 4,
  parameter int COLS      = 256,
  parameter int ROWS      = 256,
  parameter int GRAY_LUMA = 0,
  parameter int CW        = $clog2(ROWS*COLS+1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*3*PW-1:0] in_data,
  input  logic                  in_sof,
  input  logic [1:0]            mode,
  input  logic [PW-1:0]         th_lo,
  input  logic [PW-1:0]         th_hi,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*3*PW-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic [CW-1:0]         white_count,
  output logic                  frame_done,
  output logic                  sof_err,
  output logic                  fsm_state
);

  localparam int DW  = LANES*3*PW;
  localparam int NB  = COLS/LANES;
  localparam int CBW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RBW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PCW = $clog2(LANES+1);
  localparam logic [CBW-1:0]  LAST_COL = CBW'(NB-1);
  localparam logic [RBW-1:0]  LAST_ROW = RBW'(ROWS-1);
  localparam logic [3*PW-1:0] ONES     = {(3*PW){1'b1}};

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state;
  logic [CBW-1:0]    col;
  logic [RBW-1:0]    row;
  logic [1:0]        mode_sh;
  logic [PW-1:0]     lo_sh, hi_sh;

  logic              adv, accept, fwd;
  logic [CBW-1:0]    cur_col;
  logic [RBW-1:0]    cur_row;
  logic              beat_eol, beat_eof;
  logic [1:0]        eff_mode;
  logic [PW-1:0]     eff_lo, eff_hi;
  logic [LANES*PW-1:0] gray_in;

  logic              s1_valid, s1_sof, s1_eol, s1_eof;
  logic [DW-1:0]     s1_pix;
  logic [LANES*PW-1:0] s1_gray;
  logic [1:0]        s1_mode;
  logic [PW-1:0]     s1_lo, s1_hi;

  logic [LANES-1:0]  pass_vec;
  logic [DW-1:0]     thr_data;
  logic [PCW-1:0]    pass_cnt;

  logic              s2_valid, s2_sof, s2_eol, s2_eof;
  logic [DW-1:0]     s2_data;
  logic [PCW-1:0]    s2_pass;
  logic [CW-1:0]     running, count_base, count_total;

  assign adv      = !s2_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;
  // A start-of-frame beat is always taken; otherwise only mid-frame beats are.
  assign fwd      = accept & (in_sof | (state == ACTIVE));

  // Frame position of the beat on the input; sof restarts at the origin.
  assign cur_col  = in_sof ? '0 : col;
  assign cur_row  = in_sof ? '0 : row;
  assign beat_eol = (cur_col == LAST_COL);
  assign beat_eof = beat_eol & (cur_row == LAST_ROW);

  // The sof beat uses the port settings it arrives with; later beats use the shadow.
  assign eff_mode = in_sof ? mode  : mode_sh;
  assign eff_lo   = in_sof ? th_lo : lo_sh;
  assign eff_hi   = in_sof ? th_hi : hi_sh;

  assign fsm_state = (state == ACTIVE);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PW-1:0]   r, g, b, gray;
    logic [PW+1:0]   sum;
    logic [PW+7:0]   luma;
    logic            p;
    assign r    = in_data[k*3*PW        +: PW];
    assign g    = in_data[k*3*PW + PW   +: PW];
    assign b    = in_data[k*3*PW + 2*PW +: PW];
    assign sum  = {2'b00, r} + {2'b00, g} + {2'b00, b};
    assign luma = (PW+8)'(r) * (PW+8)'(77) + (PW+8)'(g) * (PW+8)'(150)
                + (PW+8)'(b) * (PW+8)'(29);
    assign gray_in[k*PW +: PW] = (GRAY_LUMA != 0) ? PW'(luma >> 8) : PW'(sum / (PW+2)'(3));

    // Stage 2 decision on the registered gray value.
    assign gray = s1_gray[k*PW +: PW];
    assign p    = (s1_mode == 2'b11) ? ((gray > s1_lo) && (gray <= s1_hi)) : (gray > s1_lo);
    assign pass_vec[k] = p;
    assign thr_data[k*3*PW +: 3*PW] =
        (s1_mode == 2'b10) ? (p ? s1_pix[k*3*PW +: 3*PW] : '0) :
        (s1_mode == 2'b01) ? (p ? '0 : ONES) :
                             (p ? ONES : '0);
  end

  // Number of passing lanes in the beat leaving stage 1.
  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < LANES; i++) pass_cnt = pass_cnt + PCW'(pass_vec[i]);
  end

  // Frame FSM, position counters, shadow thresholds and sticky restart error.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      mode_sh <= '0;
      lo_sh   <= '0;
      hi_sh   <= '0;
      sof_err <= 1'b0;
    end else if (accept) begin
      if (in_sof) begin
        mode_sh <= mode;
        lo_sh   <= th_lo;
        hi_sh   <= th_hi;
        if (state == ACTIVE) sof_err <= 1'b1;
      end
      if (fwd) begin
        if (beat_eof) begin
          state <= IDLE;
          col   <= '0;
          row   <= '0;
        end else begin
          state <= ACTIVE;
          if (beat_eol) begin
            col <= '0;
            row <= cur_row + RBW'(1);
          end else begin
            col <= cur_col + CBW'(1);
            row <= cur_row;
          end
        end
      end
    end
  end

  // Stage 1: gray values, original pixels, per-beat thresholds and position flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_gray  <= '0;
      s1_mode  <= '0;
      s1_lo    <= '0;
      s1_hi    <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (adv) begin
      s1_valid <= fwd;
      s1_pix   <= in_data;
      s1_gray  <= gray_in;
      s1_mode  <= eff_mode;
      s1_lo    <= eff_lo;
      s1_hi    <= eff_hi;
      s1_sof   <= fwd & in_sof;
      s1_eol   <= fwd & beat_eol;
      s1_eof   <= fwd & beat_eof;
    end
  end

  // Stage 2: thresholded pixels, pass count and flags presented to the sink.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_pass  <= '0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eof   <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_data  <= thr_data;
      s2_pass  <= pass_cnt;
      s2_sof   <= s1_valid & s1_sof;
      s2_eol   <= s1_valid & s1_eol;
      s2_eof   <= s1_valid & s1_eof;
    end
  end

  // A frame's count restarts with its sof beat, so an aborted frame's partial sum is dropped.
  assign count_base  = s2_sof ? '0 : running;
  assign count_total = count_base + CW'(s2_pass);

  // Running white count, committed to white_count on the eof handshake.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      running     <= '0;
      white_count <= '0;
    end else if (s2_valid && out_ready) begin
      if (s2_eof) begin
        white_count <= count_total;
        running     <= '0;
      end else begin
        running <= count_total;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_data   = s2_data;
  assign out_sof    = s2_sof;
  assign out_eol    = s2_eol;
  assign out_eof    = s2_eof;
  assign frame_done = s2_valid & out_ready & s2_eof;

endmodule

// File: tb/tb_threshold_stream_filter.sv
// Bench for threshold_stream_filter: directed vector table on an average-gray
// and a luma-gray instance, then frame-level sequences checked through an
// expected-beat queue (full frame, stalled frame with restart, reset mid-frame).
module tb_threshold_stream_filter;
  localparam int DW = 96;
  localparam int CW = 17;
  localparam int NB = 64;
  localparam int FB = 16384;
  localparam int EW = 102;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    mode = '0;
  logic [7:0]    th_lo = '0, th_hi = '0;

  logic          in_ready, out_valid, out_sof, out_eol, out_eof, frame_done, sof_err, fsm_state;
  logic [DW-1:0] out_data;
  logic [CW-1:0] white_count;
  logic          l_in_ready, l_out_valid, l_out_sof, l_out_eol, l_out_eof, l_frame_done, l_sof_err, l_fsm_state;
  logic [DW-1:0] l_out_data;
  logic [CW-1:0] l_white_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  threshold_stream_filter #(.GRAY_LUMA(0)) dut_avg (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .mode(mode), .th_lo(th_lo), .th_hi(th_hi), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .white_count(white_count), .frame_done(frame_done),
    .sof_err(sof_err), .fsm_state(fsm_state));

  threshold_stream_filter #(.GRAY_LUMA(1)) dut_luma (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .in_sof(in_sof), .mode(mode), .th_lo(th_lo), .th_hi(th_hi), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_data(l_out_data), .out_sof(l_out_sof), .out_eol(l_out_eol),
    .out_eof(l_out_eof), .white_count(l_white_count), .frame_done(l_frame_done),
    .sof_err(l_sof_err), .fsm_state(l_fsm_state));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {b, g, r};
  endfunction

  // Reference: average gray, pass rule and lane output; returns {passes, data}.
  function automatic logic [98:0] model_beat(input logic [95:0] d, input logic [1:0] m,
                                             input logic [7:0] lo, input logic [7:0] hi);
    logic [95:0] o;
    int          n, r, g, b, gray;
    logic        p;
    o = '0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      r = int'(d[k*24 +: 8]);
      g = int'(d[k*24+8 +: 8]);
      b = int'(d[k*24+16 +: 8]);
      gray = (r + g + b) / 3;
      if (m == 2'b11) p = (gray > int'(lo)) && (gray <= int'(hi));
      else            p = gray > int'(lo);
      if (p) n++;
      case (m)
        2'b10:   o[k*24 +: 24] = p ? d[k*24 +: 24] : 24'h0;
        2'b01:   o[k*24 +: 24] = p ? 24'h0 : 24'hFFFFFF;
        default: o[k*24 +: 24] = p ? 24'hFFFFFF : 24'h0;
      endcase
    end
    return {3'(n), o};
  endfunction

  // Scoreboard and frame model state.
  logic [EW-1:0] exp_q[$];
  logic          m_active, exp_sof_err, prev_stall;
  int            m_pos, exp_run, exp_white, fd_seen;
  logic [1:0]    m_mode;
  logic [7:0]    m_lo, m_hi;
  logic [DW-1:0] prev_data;

  task automatic model_clear();
    exp_q.delete();
    m_active = 1'b0; exp_sof_err = 1'b0; prev_stall = 1'b0;
    m_pos = 0; exp_run = 0; exp_white = 0;
    m_mode = '0; m_lo = '0; m_hi = '0; prev_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  // One cycle: drive inputs at the falling edge, then check and update the model.
  task automatic step(input logic v, input logic [95:0] d, input logic s, input logic r,
                      output logic acc);
    logic [98:0]   mb;
    logic [EW-1:0] rec;
    logic          eol, eof;
    @(negedge clk);
    in_valid = v; in_data = d; in_sof = s; out_ready = r;
    #1;
    check("white_count", white_count, exp_white);
    check("sof_err", sof_err, exp_sof_err);
    if (frame_done) fd_seen++;
    if (prev_stall) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, prev_data);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_beat: got data %0h expected no beat", out_data);
      end else begin
        rec = exp_q.pop_front();
        check("out_data", out_data, rec[95:0]);
        check("out_sof", out_sof, rec[98]);
        check("out_eol", out_eol, rec[97]);
        check("out_eof", out_eof, rec[96]);
        check("frame_done", frame_done, rec[96]);
        if (rec[98]) exp_run = int'(rec[101:99]);
        else         exp_run = exp_run + int'(rec[101:99]);
        if (rec[96]) begin exp_white = exp_run; exp_run = 0; end
      end
    end else begin
      check("frame_done_idle", frame_done, 1'b0);
    end
    acc = in_valid && in_ready;
    if (acc) begin
      if (s) begin
        if (m_active) exp_sof_err = 1'b1;
        m_active = 1'b1; m_pos = 0;
        m_mode = mode; m_lo = th_lo; m_hi = th_hi;
      end
      if (m_active) begin
        mb  = model_beat(d, m_mode, m_lo, m_hi);
        eol = (m_pos % NB) == NB - 1;
        eof = m_pos == FB - 1;
        exp_q.push_back({mb[98:96], s, eol, eof, mb[95:0]});
        m_pos++;
        if (eof) m_active = 1'b0;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  m;
    logic [7:0]  lo, hi;
    logic [95:0] d, e_avg, e_luma;
  } vec_t;
  vec_t vecs[7];

  task automatic set_vec(input int i, input string name, input logic [1:0] m, input logic [7:0] lo,
                         input logic [7:0] hi, input logic [95:0] d, input logic [95:0] ea,
                         input logic [95:0] el);
    vecs[i].name = name; vecs[i].m = m; vecs[i].lo = lo; vecs[i].hi = hi;
    vecs[i].d = d; vecs[i].e_avg = ea; vecs[i].e_luma = el;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected test end");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc;
    logic [95:0]   d200, rd;
    int            n;

    d200 = {px(200,200,200), px(200,200,200), px(200,200,200), px(200,200,200)};
    set_vec(0, "bin_40", 2'b00, 8'd40, 8'd0,
            {px(255,255,255), px(0,0,0), px(40,40,40), px(41,41,41)},
            {24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF}, {24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF});
    set_vec(1, "tozero_100", 2'b10, 8'd100, 8'd0,
            {px(100,100,100), px(101,101,101), px(10,20,30), px(200,150,10)},
            {24'h0, px(101,101,101), 24'h0, px(200,150,10)},
            {24'h0, px(101,101,101), 24'h0, px(200,150,10)});
    set_vec(2, "green_100", 2'b00, 8'd100, 8'd0,
            {72'h0, px(0,255,0)}, 96'h0, {72'h0, 24'hFFFFFF});
    set_vec(3, "band_50_60", 2'b11, 8'd50, 8'd60,
            {px(61,61,61), px(60,60,60), px(55,55,55), px(50,50,50)},
            {24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0}, {24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0});
    set_vec(4, "band_inv", 2'b11, 8'd60, 8'd50,
            {px(61,61,61), px(60,60,60), px(55,55,55), px(50,50,50)}, 96'h0, 96'h0);
    set_vec(5, "inv_40", 2'b01, 8'd40, 8'd0,
            {px(255,255,255), px(0,0,0), px(40,40,40), px(41,41,41)},
            {24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0}, {24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0});
    set_vec(6, "tozero_0", 2'b10, 8'd0, 8'd0,
            {px(0,0,0), px(255,255,255), px(3,0,0), px(1,0,0)},
            {24'h0, 24'hFFFFFF, px(3,0,0), 24'h0}, {24'h0, 24'hFFFFFF, 24'h0, 24'h0});

    // Reset state, sampled while reset is held.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 96'h0);
    check("rst_flags", {out_sof, out_eol, out_eof, frame_done, sof_err}, 5'b0);
    check("rst_white", white_count, 17'h0);
    check("rst_state", fsm_state, 1'b0);

    // Vector table: each vector is a fresh frame's first beat.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      @(negedge clk);
      mode = vecs[i].m; th_lo = vecs[i].lo; th_hi = vecs[i].hi;
      in_data = vecs[i].d; in_sof = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0;
      check({vecs[i].name, "_lat1"}, out_valid, 1'b0);
      @(negedge clk);
      check({vecs[i].name, "_valid"}, out_valid, 1'b1);
      check({vecs[i].name, "_avg"}, out_data, vecs[i].e_avg);
      check({vecs[i].name, "_luma"}, l_out_data, vecs[i].e_luma);
      check({vecs[i].name, "_flags"}, {out_sof, out_eol, out_eof}, 3'b100);
    end

    // Full frame, inverted binary on gray 200; leading beats without sof are dropped.
    do_reset();
    fd_seen = 0;
    mode = 2'b01; th_lo = 8'd40; th_hi = 8'd0;
    for (int i = 0; i < 3; i++) step(1'b1, d200, 1'b0, 1'b1, acc);
    for (int i = 0; i < FB; i++) step(1'b1, d200, i == 0, 1'b1, acc);
    drain();
    check("white_full", white_count, 17'd65536);
    check("fd_full", 32'(fd_seen), 1);

    // Random stalls; 100-beat frame aborted by a new sof, then a full frame.
    mode = 2'b00; th_lo = 8'd127; th_hi = 8'd0;
    n = 0;
    for (int c = 0; c < 2000 && n < 100; c++) begin
      rd = {$urandom(), $urandom(), $urandom()};
      step($urandom_range(0, 9) < 8, rd, n == 0, $urandom_range(0, 1) == 1, acc);
      if (acc) n++;
    end
    check("feed_abort", 32'(n), 100);
    mode = 2'b00; th_lo = 8'd90; th_hi = 8'd0;
    n = 0;
    for (int c = 0; c < 60000 && n < FB; c++) begin
      rd = {$urandom(), $urandom(), $urandom()};
      step($urandom_range(0, 9) < 8, rd, n == 0, $urandom_range(0, 1) == 1, acc);
      if (acc) n++;
      if (n == 10) begin mode = 2'b01; th_lo = 8'd200; end
    end
    check("feed_frame", 32'(n), FB);
    drain();
    check("sof_err_set", sof_err, 1'b1);
    check("fd_total", 32'(fd_seen), 2);

    // Reset asserted in the middle of a frame.
    mode = 2'b00; th_lo = 8'd10;
    for (int i = 0; i < 20; i++) step(1'b1, d200, i == 0, 1'b1, acc);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_data", out_data, 96'h0);
    check("mrst_flags", {out_sof, out_eol, out_eof, frame_done, sof_err}, 5'b0);
    check("mrst_white", white_count, 17'h0);
    check("mrst_state", fsm_state, 1'b0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, d200, 1'b0, 1'b1, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
